pcs_receive: RTL and testbench

PCS_RECEIVE -- requirements
Module: pcs_receive

---
 rtl/pcs_rx_pkg.sv | 53 +++++
 rtl/pcs_receive_if.sv | 44 ++++
 rtl/pcs_10b8b_decode.sv | 109 ++++++++++
 rtl/pcs_receive.sv | 152 +++++++++++++++
 tb/tb_pcs_receive.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_rx_pkg
//  Description : Shared definitions for the 1000BASE-X PCS receive path.
//                Holds the special code-group encodings (both running
//                disparities), the receive state encoding and the fixed
//                GMII octets the receive state machine emits.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pcs_rx_pkg;

   // One ten-bit code-group, bits [9:4] = abcdei, [3:0] = fghj.
   typedef logic [9:0] code_group_t;

   // Special code-groups, RD- and RD+ columns.
   localparam code_group_t K28_5_RDN = 10'b0011111010;   // comma
   localparam code_group_t K28_5_RDP = 10'b1100000101;
   localparam code_group_t K27_7_RDN = 10'b1101101000;   // /S/
   localparam code_group_t K27_7_RDP = 10'b0010010111;
   localparam code_group_t K29_7_RDN = 10'b1011101000;   // /T/
   localparam code_group_t K29_7_RDP = 10'b0100010111;
   localparam code_group_t K23_7_RDN = 10'b1110101000;   // /R/
   localparam code_group_t K23_7_RDP = 10'b0001010111;

   // Octets of the data code-groups that complete an /I1/ or /I2/ ordered set.
   localparam logic [7:0] OCTET_D16_2 = 8'h50;
   localparam logic [7:0] OCTET_D5_6  = 8'hC5;

   // Fixed octets placed on rxd.
   localparam logic [7:0] RXD_PREAMBLE      = 8'h55;
   localparam logic [7:0] RXD_FALSE_CARRIER = 8'h0E;

   typedef enum logic [2:0] {
      ST_LINK_FAILED   = 3'd0,
      ST_WAIT_FOR_K    = 3'd1,
      ST_RX_K          = 3'd2,
      ST_IDLE_D        = 3'd3,
      ST_FALSE_CARRIER = 3'd4,
      ST_RECEIVE       = 3'd5,
      ST_EARLY_END     = 3'd6,
      ST_TRI_RRI       = 3'd7
   } rx_state_t;

   // True when the code-group equals either disparity form of a special.
   function automatic logic match_either(input code_group_t code,
                                         input code_group_t rdn,
                                         input code_group_t rdp);
      return (code == rdn) || (code == rdp);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_receive_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_receive_if
//  Description : Bundle between the synchronization stage / GMII side and the
//                PCS receive block.
//  Signals     : sync_status, rx_even, sudi  - aligned code-group stream
//                rxd, rx_dv, rx_er, receiving - decoded GMII receive side
//  Modports    : master - drives the code-group stream, observes GMII outputs
//                slave  - the PCS receive block
//  Revision    : 1.0 - initial release
// ============================================================================
interface pcs_receive_if;
   import pcs_rx_pkg::*;

   logic        sync_status;
   logic        rx_even;
   code_group_t sudi;
   logic [7:0]  rxd;
   logic        rx_dv;
   logic        rx_er;
   logic        receiving;

   modport master (
      output sync_status,
      output rx_even,
      output sudi,
      input  rxd,
      input  rx_dv,
      input  rx_er,
      input  receiving
   );

   modport slave (
      input  sync_status,
      input  rx_even,
      input  sudi,
      output rxd,
      output rx_dv,
      output rx_er,
      output receiving
   );

endinterface
`default_nettype wire

// File: rtl/pcs_10b8b_decode.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_10b8b_decode
//  Description : Combinational, disparity-agnostic 10b/8b classifier. A
//                code-group is data when its 6b and 4b sub-blocks each match
//                either running-disparity column; the four recognised special
//                code-groups take precedence over the data lookup.
//  Ports       : code     in  10  aligned code-group (abcdei fghj)
//                octet    out 8   decoded HGF EDCBA value (valid with is_data)
//                is_data  out 1   valid data code-group
//                is_k285  out 1   K28.5
//                is_s     out 1   /S/ K27.7
//                is_t     out 1   /T/ K29.7
//                is_r     out 1   /R/ K23.7
//                invalid  out 1   neither data nor a recognised special
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_10b8b_decode
   import pcs_rx_pkg::*;
(
   input  code_group_t code,
   output logic [7:0]  octet,
   output logic        is_data,
   output logic        is_k285,
   output logic        is_s,
   output logic        is_t,
   output logic        is_r,
   output logic        invalid
);

   logic [4:0] edcba;
   logic [2:0] hgf;
   logic       six_ok;
   logic       four_ok;
   logic       special;

   // 6b/5b lookup; both disparity forms share one label line.
   always_comb begin
      six_ok = 1'b1;
      edcba  = 5'd0;
      case (code[9:4])
         6'b100111, 6'b011000: edcba = 5'd0;
         6'b011101, 6'b100010: edcba = 5'd1;
         6'b101101, 6'b010010: edcba = 5'd2;
         6'b110001:            edcba = 5'd3;
         6'b110101, 6'b001010: edcba = 5'd4;
         6'b101001:            edcba = 5'd5;
         6'b011001:            edcba = 5'd6;
         6'b111000, 6'b000111: edcba = 5'd7;
         6'b111001, 6'b000110: edcba = 5'd8;
         6'b100101:            edcba = 5'd9;
         6'b010101:            edcba = 5'd10;
         6'b110100:            edcba = 5'd11;
         6'b001101:            edcba = 5'd12;
         6'b101100:            edcba = 5'd13;
         6'b011100:            edcba = 5'd14;
         6'b010111, 6'b101000: edcba = 5'd15;
         6'b011011, 6'b100100: edcba = 5'd16;
         6'b100011:            edcba = 5'd17;
         6'b010011:            edcba = 5'd18;
         6'b110010:            edcba = 5'd19;
         6'b001011:            edcba = 5'd20;
         6'b101010:            edcba = 5'd21;
         6'b011010:            edcba = 5'd22;
         6'b111010, 6'b000101: edcba = 5'd23;
         6'b110011, 6'b001100: edcba = 5'd24;
         6'b100110:            edcba = 5'd25;
         6'b010110:            edcba = 5'd26;
         6'b110110, 6'b001001: edcba = 5'd27;
         6'b001110:            edcba = 5'd28;
         6'b101110, 6'b010001: edcba = 5'd29;
         6'b011110, 6'b100001: edcba = 5'd30;
         6'b101011, 6'b010100: edcba = 5'd31;
         default:              six_ok = 1'b0;
      endcase
   end

   // 4b/3b lookup; x.7 accepts both the primary and the alternate encoding.
   always_comb begin
      four_ok = 1'b1;
      hgf     = 3'd0;
      case (code[3:0])
         4'b1011, 4'b0100:                   hgf = 3'd0;
         4'b1001:                            hgf = 3'd1;
         4'b0101:                            hgf = 3'd2;
         4'b1100, 4'b0011:                   hgf = 3'd3;
         4'b1101, 4'b0010:                   hgf = 3'd4;
         4'b1010:                            hgf = 3'd5;
         4'b0110:                            hgf = 3'd6;
         4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
         default:                            four_ok = 1'b0;
      endcase
   end

   always_comb begin
      is_k285 = match_either(code, K28_5_RDN, K28_5_RDP);
      is_s    = match_either(code, K27_7_RDN, K27_7_RDP);
      is_t    = match_either(code, K29_7_RDN, K29_7_RDP);
      is_r    = match_either(code, K23_7_RDN, K23_7_RDP);
      // Some specials (e.g. K27.7) also fit the alternate-x.7 data pattern,
      // so the special match masks the data result.
      special = is_k285 | is_s | is_t | is_r;
      is_data = six_ok & four_ok & ~special;
      invalid = ~special & ~is_data;
      octet   = {hgf, edcba};
   end

endmodule
`default_nettype wire

// File: rtl/pcs_receive.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_receive
//  Description : 1000BASE-X PCS receive state machine. Classifies each
//                aligned code-group and produces registered GMII receive
//                signals one clock after the code-group is sampled.
//  Ports       : clk    in   rising-edge clock
//                reset  in   synchronous active-low reset
//                rx     slave modport of pcs_receive_if
//                       (sync_status, rx_even, sudi in;
//                        rxd, rx_dv, rx_er, receiving out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_receive
   import pcs_rx_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   pcs_receive_if.slave rx
);

   rx_state_t  state;
   logic [7:0] rxd_reg;
   logic       rx_dv_reg;
   logic       rx_er_reg;
   logic       receiving_reg;

   logic [7:0] dec_octet;
   logic       dec_data;
   logic       dec_k285;
   logic       dec_s;
   logic       dec_t;
   logic       dec_r;
   logic       dec_invalid;

   logic       k_even;
   logic       idle_data;
   logic       code_error;

   pcs_10b8b_decode u_decode (
      .code    (rx.sudi),
      .octet   (dec_octet),
      .is_data (dec_data),
      .is_k285 (dec_k285),
      .is_s    (dec_s),
      .is_t    (dec_t),
      .is_r    (dec_r),
      .invalid (dec_invalid)
   );

   // Commas only count for alignment on even code-group positions.
   assign k_even     = dec_k285 & rx.rx_even;
   // Second code-group of an /I1/ or /I2/ ordered set.
   assign idle_data  = dec_data & ((dec_octet == OCTET_D16_2) || (dec_octet == OCTET_D5_6));
   // Inside a packet, a stray /S/ or /R/ is treated like a corrupted code-group.
   assign code_error = dec_invalid | dec_s | dec_r;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_LINK_FAILED;
         rxd_reg       <= 8'h00;
         rx_dv_reg     <= 1'b0;
         rx_er_reg     <= 1'b0;
         receiving_reg <= 1'b0;
      end else if (!rx.sync_status) begin
         // Loss of sync flags an error only when it cuts a packet short;
         // receiving then drops, so the flag lasts a single cycle.
         state         <= ST_LINK_FAILED;
         rxd_reg       <= 8'h00;
         rx_dv_reg     <= 1'b0;
         rx_er_reg     <= receiving_reg;
         receiving_reg <= 1'b0;
      end else begin
         rxd_reg       <= 8'h00;
         rx_dv_reg     <= 1'b0;
         rx_er_reg     <= 1'b0;
         receiving_reg <= 1'b0;
         case (state)
            ST_LINK_FAILED: begin
               state <= ST_WAIT_FOR_K;
            end
            ST_WAIT_FOR_K: begin
               if (k_even) state <= ST_RX_K;
            end
            ST_RX_K: begin
               state <= idle_data ? ST_IDLE_D : ST_WAIT_FOR_K;
            end
            ST_IDLE_D: begin
               if (k_even) begin
                  state <= ST_RX_K;
               end else if (dec_s) begin
                  state         <= ST_RECEIVE;
                  rxd_reg       <= RXD_PREAMBLE;
                  rx_dv_reg     <= 1'b1;
                  receiving_reg <= 1'b1;
               end else begin
                  state     <= ST_FALSE_CARRIER;
                  rxd_reg   <= RXD_FALSE_CARRIER;
                  rx_er_reg <= 1'b1;
               end
            end
            ST_FALSE_CARRIER: begin
               if (k_even) begin
                  state <= ST_RX_K;
               end else begin
                  rxd_reg   <= RXD_FALSE_CARRIER;
                  rx_er_reg <= 1'b1;
               end
            end
            ST_RECEIVE: begin
               if (dec_t) begin
                  state <= ST_TRI_RRI;
               end else if (dec_k285) begin
                  state     <= ST_EARLY_END;
                  rx_er_reg <= 1'b1;
               end else if (code_error) begin
                  rx_dv_reg     <= 1'b1;
                  rx_er_reg     <= 1'b1;
                  receiving_reg <= 1'b1;
               end else begin
                  rxd_reg       <= dec_octet;
                  rx_dv_reg     <= 1'b1;
                  receiving_reg <= 1'b1;
               end
            end
            ST_EARLY_END: begin
               // The code-group seen here is not examined.
               state <= ST_RX_K;
            end
            ST_TRI_RRI: begin
               if (dec_r) begin
                  state <= ST_TRI_RRI;
               end else if (k_even) begin
                  state <= ST_RX_K;
               end else begin
                  state <= ST_WAIT_FOR_K;
               end
            end
            default: begin
               state <= ST_LINK_FAILED;
            end
         endcase
      end
   end

   assign rx.rxd       = rxd_reg;
   assign rx.rx_dv     = rx_dv_reg;
   assign rx.rx_er     = rx_er_reg;
   assign rx.receiving = receiving_reg;

endmodule
`default_nettype wire

// File: tb/tb_pcs_receive.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcs_receive
//  Description : Self-checking bench for pcs_receive: a directed vector table
//                followed by a randomized code-group stream checked against a
//                behavioural reference model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_receive;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pcs_receive_if bus ();

   pcs_receive dut (
      .clk   (clk),
      .reset (reset),
      .rx    (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Code-groups used by the directed table.
   localparam logic [9:0] K_N  = 10'b0011111010;
   localparam logic [9:0] K_P  = 10'b1100000101;
   localparam logic [9:0] D162 = 10'b0110110101;
   localparam logic [9:0] D56  = 10'b1010010110;
   localparam logic [9:0] S_P  = 10'b0010010111;
   localparam logic [9:0] S_N  = 10'b1101101000;
   localparam logic [9:0] T_P  = 10'b0100010111;
   localparam logic [9:0] T_N  = 10'b1011101000;
   localparam logic [9:0] R_N  = 10'b1110101000;
   localparam logic [9:0] R_P  = 10'b0001010111;
   localparam logic [9:0] D4_0 = 10'b0010101011;
   localparam logic [9:0] D8_0 = 10'b1110010100;
   localparam logic [9:0] D3_0 = 10'b1100011011;
   localparam logic [9:0] BAD  = 10'b1111111111;

   // 8b/10b column tables for the reference model, indexed by EDCBA / HGF.
   logic [5:0] six_m [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001,
                              6'b110101, 6'b101001, 6'b011001, 6'b111000,
                              6'b111001, 6'b100101, 6'b010101, 6'b110100,
                              6'b001101, 6'b101100, 6'b011100, 6'b010111,
                              6'b011011, 6'b100011, 6'b010011, 6'b110010,
                              6'b001011, 6'b101010, 6'b011010, 6'b111010,
                              6'b110011, 6'b100110, 6'b010110, 6'b110110,
                              6'b001110, 6'b101110, 6'b011110, 6'b101011};
   logic [5:0] six_p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001,
                              6'b001010, 6'b101001, 6'b011001, 6'b000111,
                              6'b000110, 6'b100101, 6'b010101, 6'b110100,
                              6'b001101, 6'b101100, 6'b011100, 6'b101000,
                              6'b100100, 6'b100011, 6'b010011, 6'b110010,
                              6'b001011, 6'b101010, 6'b011010, 6'b000101,
                              6'b001100, 6'b100110, 6'b010110, 6'b001001,
                              6'b001110, 6'b010001, 6'b100001, 6'b010100};
   logic [3:0] four_m [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                              4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] four_p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                              4'b0010, 4'b1010, 4'b0110, 4'b0001};

   localparam int CL_DATA = 0, CL_K = 1, CL_S = 2, CL_T = 3, CL_R = 4, CL_BAD = 5;

   function automatic int classify(input logic [9:0] c, output logic [7:0] oct);
      int x;
      int y;
      x   = -1;
      y   = -1;
      oct = 8'h00;
      if (c == K_N || c == K_P) return CL_K;
      if (c == S_N || c == S_P) return CL_S;
      if (c == T_N || c == T_P) return CL_T;
      if (c == R_N || c == R_P) return CL_R;
      for (int i = 0; i < 32; i++)
         if (c[9:4] == six_m[i] || c[9:4] == six_p[i]) x = i;
      for (int j = 0; j < 8; j++)
         if (c[3:0] == four_m[j] || c[3:0] == four_p[j]) y = j;
      if (c[3:0] == 4'b0111 || c[3:0] == 4'b1000) y = 7;
      if (x < 0 || y < 0) return CL_BAD;
      oct = 8'(y * 32 + x);
      return CL_DATA;
   endfunction

   // Reference model: phase of the link plus expected outputs.
   localparam int M_LINK = 0, M_WAITK = 1, M_RXK = 2, M_IDLE = 3;
   localparam int M_FC = 4, M_PKT = 5, M_EARLY = 6, M_TRI = 7;
   int          m_phase;
   logic        m_recv;
   logic [10:0] m_exp;   // {rxd, rx_dv, rx_er, receiving}

   task automatic model_step(input logic rst_n, input logic sync, input logic even,
                             input logic [9:0] code);
      int         cls;
      logic [7:0] oct;
      logic       comma;
      cls   = classify(code, oct);
      comma = (cls == CL_K) && even;
      if (!rst_n) begin
         m_phase = M_LINK;
         m_exp   = 11'd0;
      end else if (!sync) begin
         m_exp   = {8'h00, 1'b0, m_recv, 1'b0};
         m_phase = M_LINK;
      end else begin
         m_exp = 11'd0;
         if (m_phase == M_LINK) m_phase = M_WAITK;
         else if (m_phase == M_WAITK) begin
            if (comma) m_phase = M_RXK;
         end else if (m_phase == M_RXK) begin
            m_phase = (cls == CL_DATA && (oct == 8'h50 || oct == 8'hC5)) ? M_IDLE : M_WAITK;
         end else if (m_phase == M_IDLE) begin
            if (comma) m_phase = M_RXK;
            else if (cls == CL_S) begin
               m_phase = M_PKT;
               m_exp   = {8'h55, 3'b101};
            end else begin
               m_phase = M_FC;
               m_exp   = {8'h0E, 3'b010};
            end
         end else if (m_phase == M_FC) begin
            if (comma) m_phase = M_RXK;
            else m_exp = {8'h0E, 3'b010};
         end else if (m_phase == M_PKT) begin
            if (cls == CL_T) m_phase = M_TRI;
            else if (cls == CL_K) begin
               m_phase = M_EARLY;
               m_exp   = {8'h00, 3'b010};
            end else if (cls == CL_DATA) m_exp = {oct, 3'b101};
            else m_exp = {8'h00, 3'b111};
         end else if (m_phase == M_EARLY) begin
            m_phase = M_RXK;
         end else begin
            if (cls == CL_R) m_phase = M_TRI;
            else if (comma) m_phase = M_RXK;
            else m_phase = M_WAITK;
         end
      end
      m_recv = m_exp[0];
   endtask

   task automatic apply(input logic rst_n, input logic sync, input logic even,
                        input logic [9:0] code);
      reset           = rst_n;
      bus.sync_status = sync;
      bus.rx_even     = even;
      bus.sudi        = code;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [10:0] exp);
      logic [10:0] got;
      got = {bus.rxd, bus.rx_dv, bus.rx_er, bus.receiving};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got rxd=%h dv=%b er=%b recv=%b, expected rxd=%h dv=%b er=%b recv=%b",
                  name, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   typedef struct {
      logic       rst_n;
      logic       sync;
      logic       even;
      logic [9:0] code;
      logic [7:0] rxd;
      logic       dv;
      logic       er;
      logic       recv;
   } vec_t;

   vec_t vecs[$];

   function automatic void addv(input logic rst_n, input logic sync, input logic even,
                                input logic [9:0] code, input logic [7:0] rxd,
                                input logic dv, input logic er, input logic recv);
      vec_t v;
      v.rst_n = rst_n; v.sync = sync; v.even = even; v.code = code;
      v.rxd = rxd; v.dv = dv; v.er = er; v.recv = recv;
      vecs.push_back(v);
   endfunction

   logic [9:0]  rcode;
   logic        reven;
   logic        rsync;
   logic        rrst;
   int unsigned pick;
   int unsigned xi;
   int unsigned yi;
   logic [5:0]  s6;
   logic [3:0]  f4;

   initial begin
      reset           = 1'b0;
      bus.sync_status = 1'b0;
      bus.rx_even     = 1'b0;
      bus.sudi        = 10'd0;

      // rst sync even code         rxd   dv er recv
      addv(0, 0, 0, K_N,   8'h00, 0, 0, 0);   // reset state
      addv(0, 1, 1, K_N,   8'h00, 0, 0, 0);
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);   // LINK_FAILED -> WAIT_FOR_K
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);   // -> RX_K
      addv(1, 1, 0, D162,  8'h00, 0, 0, 0);   // -> IDLE_D
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);   // -> RX_K
      addv(1, 1, 0, D162,  8'h00, 0, 0, 0);   // -> IDLE_D
      addv(1, 1, 1, S_P,   8'h55, 1, 0, 1);   // start of packet
      addv(1, 1, 0, D4_0,  8'h04, 1, 0, 1);
      addv(1, 1, 1, T_P,   8'h00, 0, 0, 0);   // end of packet
      addv(1, 1, 0, R_N,   8'h00, 0, 0, 0);   // /R/ holds TRI_RRI
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);   // -> RX_K
      addv(1, 1, 0, D56,   8'h00, 0, 0, 0);   // /I1/ second half -> IDLE_D
      addv(1, 1, 1, S_N,   8'h55, 1, 0, 1);
      addv(1, 1, 0, BAD,   8'h00, 1, 1, 1);   // invalid in packet
      addv(1, 1, 1, D8_0,  8'h08, 1, 0, 1);
      addv(1, 1, 0, R_P,   8'h00, 1, 1, 1);   // unexpected /R/
      addv(1, 1, 1, S_P,   8'h00, 1, 1, 1);   // unexpected /S/
      addv(1, 1, 1, K_P,   8'h00, 0, 1, 0);   // early end
      addv(1, 1, 0, D162,  8'h00, 0, 0, 0);   // EARLY_END -> RX_K
      addv(1, 1, 1, D162,  8'h00, 0, 0, 0);   // RX_K -> IDLE_D
      addv(1, 1, 0, D3_0,  8'h0E, 0, 1, 0);   // false carrier
      addv(1, 1, 1, D8_0,  8'h0E, 0, 1, 0);
      addv(1, 1, 0, K_N,   8'h0E, 0, 1, 0);   // odd comma does not recover
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);   // -> RX_K
      addv(1, 1, 0, D162,  8'h00, 0, 0, 0);
      addv(1, 1, 1, S_P,   8'h55, 1, 0, 1);
      addv(1, 0, 0, D162,  8'h00, 0, 1, 0);   // sync loss mid-packet
      addv(1, 0, 1, D162,  8'h00, 0, 0, 0);   // error flag lasts one cycle
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);
      addv(1, 1, 0, D162,  8'h00, 0, 0, 0);
      addv(1, 1, 1, S_P,   8'h55, 1, 0, 1);
      addv(1, 1, 0, D4_0,  8'h04, 1, 0, 1);
      addv(0, 1, 1, D4_0,  8'h00, 0, 0, 0);   // reset mid-packet, no error
      addv(1, 1, 1, K_N,   8'h00, 0, 0, 0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst_n, vecs[i].sync, vecs[i].even, vecs[i].code);
         check($sformatf("vec%0d", i), {vecs[i].rxd, vecs[i].dv, vecs[i].er, vecs[i].recv});
      end

      // Randomized stream against the reference model.
      m_phase = M_LINK;
      m_recv  = 1'b0;
      reven   = 1'b0;
      model_step(1'b0, 1'b0, 1'b0, 10'd0);
      apply(1'b0, 1'b0, 1'b0, 10'd0);
      check("rand_reset", m_exp);
      for (int n = 0; n < 4000; n++) begin
         pick = $urandom_range(0, 99);
         if (pick < 25)      rcode = ($urandom_range(0, 1) != 0) ? K_N : K_P;
         else if (pick < 40) begin
            xi = $urandom_range(0, 2);
            rcode = (xi == 0) ? D162 : (xi == 1) ? 10'b1001000101 : D56;
         end
         else if (pick < 50) rcode = ($urandom_range(0, 1) != 0) ? S_N : S_P;
         else if (pick < 75) begin
            xi = $urandom_range(0, 31);
            yi = $urandom_range(0, 7);
            s6 = ($urandom_range(0, 1) != 0) ? six_p[xi] : six_m[xi];
            f4 = ($urandom_range(0, 1) != 0) ? four_p[yi] : four_m[yi];
            if (yi == 7 && $urandom_range(0, 1) != 0)
               f4 = ($urandom_range(0, 1) != 0) ? 4'b0111 : 4'b1000;
            rcode = {s6, f4};
         end
         else if (pick < 82) rcode = ($urandom_range(0, 1) != 0) ? T_N : T_P;
         else if (pick < 88) rcode = ($urandom_range(0, 1) != 0) ? R_N : R_P;
         else                rcode = 10'($urandom);
         if ($urandom_range(0, 9) != 0) reven = ~reven;
         rsync = ($urandom_range(0, 99) >= 2);
         rrst  = ($urandom_range(0, 199) != 0);
         model_step(rrst, rsync, reven, rcode);
         apply(rrst, rsync, reven, rcode);
         check($sformatf("rand%0d code=%b", n, rcode), m_exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
